// File: rtl/sh_mem_pkg.sv
// Shared types and byte-lane helpers for the CPU-side memory port master.
// Lane numbering is big-endian: byte offset 0 is bits [31:24].
package sh_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        WORD = 2'b01,
        LONG = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RMW_WR  = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Size 11 is illegal; WORD needs even address, LONG needs 4-byte alignment.
    function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || ((size == WORD) && off[0]) || ((size == LONG) && (off != 2'b00));
    endfunction

    // Right-shift that brings the addressed lane down to bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        case (size)
            BYTE:    return {~off, 3'b000};
            WORD:    return {~off[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            BYTE:    return 32'h0000_00FF;
            WORD:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Pull the addressed lane out of a RAM word, zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] d, input logic [1:0] size,
                                                 input logic [1:0] off);
        return (d >> lane_shift(size, off)) & lane_mask(size);
    endfunction

    // Replace only the addressed lane of a RAM word with right-aligned write data.
    function automatic logic [31:0] lane_merge(input logic [31:0] d, input logic [31:0] w,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] m;
        m = lane_mask(size) << lane_shift(size, off);
        return (d & ~m) | ((w << lane_shift(size, off)) & m);
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Two-entry response FIFO. A push is visible at the head the next cycle;
// push and pop together are legal at any occupancy. Head reads 0 when empty.
module mem_rsp_fifo #(
    parameter type T = logic
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  T           din,
    output logic       valid,
    input  logic       ready,
    output T           dout,
    output logic [1:0] cnt
);

    T     mem [2];
    logic wp;
    logic rp;
    logic pop;

    assign valid = (cnt != 2'd0);
    assign pop   = valid && ready;
    assign dout  = valid ? mem[rp] : '0;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_master.sv
// CPU-side master for one port of a dual-port word RAM. Handles byte/word/long
// accesses; sub-word writes are read-modify-write over two cycles.
import sh_mem_pkg::*;

module mem_port_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_e                state;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q;
    logic [1:0]            fifo_cnt;
    logic                  inflight;
    logic                  acc;
    logic                  bad;
    logic                  push;
    rsp_t                  push_d;
    rsp_t                  head;

    // A non-IDLE state always owes exactly one response next cycle.
    assign inflight  = (state != IDLE);
    assign req_ready = rst_n && (state == IDLE) && (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2);
    assign acc       = req_valid && req_ready;
    assign bad       = size_err(req_size, req_addr[1:0]);

    // RAM port drive and FIFO push, decided from state and the accepted request.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        push      = 1'b0;
        push_d    = '0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (bad) begin
                        push       = 1'b1;
                        push_d.err = 1'b1;
                    end else if (req_we && (req_size == LONG)) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = req_addr[ADDR_WIDTH+1:2];
                        ram_wdata = req_wdata;
                        push      = 1'b1;
                    end else begin
                        // Reads and the read half of a read-modify-write.
                        ram_en   = 1'b1;
                        ram_addr = req_addr[ADDR_WIDTH+1:2];
                    end
                end
            end
            RD_WAIT: begin
                push         = 1'b1;
                push_d.rdata = lane_extract(ram_rdata, size_q, addr_q[1:0]);
            end
            RMW_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q[ADDR_WIDTH+1:2];
                ram_wdata = lane_merge(ram_rdata, wdata_q, size_q, addr_q[1:0]);
                push      = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM and request latch; only two-cycle accesses leave IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && !bad && !(req_we && (req_size == LONG))) begin
                        state   <= req_we ? RMW_WR : RD_WAIT;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rsp_fifo #(.T(rsp_t)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_d),
        .valid (rsp_valid),
        .ready (rsp_ready),
        .dout  (head),
        .cnt   (fifo_cnt)
    );

    assign rsp_rdata = head.rdata;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: behavioural RAM, expected-response queue, direct
// checks on RAM side effects, handshake timing and reset behaviour.
module tb_mem_port_master;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    logic [31:0]   mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;
    logic acc_en;
    logic acc_we;

    mem_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, read data one cycle after the enable.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor: compare the head every cycle it is shown, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb[0].lat != 0) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
                chk("rsp_rdata", rsp_rdata, sb[0].rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb[0].err});
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic [AW+1:0] a,
                         input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
    endtask

    // Wait for the accept cycle, note RAM strobes there, queue the expected response.
    task automatic wait_acc(input logic [31:0] er, input logic ee, input int lat, input bit push_exp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc_en = ram_en;
            acc_we = ram_we;
            if (push_exp) sb.push_back('{er, ee, lat, cyc});
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic [AW+1:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
        drive(we, sz, a, wd);
        wait_acc(er, ee, lat, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        #1;
    endtask

    initial begin
        // Reset values.
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // LONG write then LONG read of 0x10.
        send(1'b1, 2'b10, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        chk("lw_ram_en", {31'd0, acc_en}, 32'd1);
        chk("lw_ram_we", {31'd0, acc_we}, 32'd1);
        send(1'b0, 2'b10, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        drain();
        chk("ram4_long", mem[4], 32'hDEADBEEF);

        // BYTE read-modify-write into word 4.
        send(1'b1, 2'b10, 10'h010, 32'h11223344, 32'h0, 1'b0, 1);
        send(1'b1, 2'b00, 10'h012, 32'h000000AA, 32'h0, 1'b0, 2);
        chk("bw_ram_en", {31'd0, acc_en}, 32'd1);
        chk("bw_ram_we", {31'd0, acc_we}, 32'd0);
        @(negedge clk);
        chk("rmw_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rmw_ready_back", {31'd0, req_ready}, 32'd1);
        send(1'b0, 2'b00, 10'h012, 32'h0, 32'h000000AA, 1'b0, 2);
        drain();
        chk("ram4_byte", mem[4], 32'h1122AA44);

        // Misaligned WORD read: no RAM access, error in one cycle.
        send(1'b0, 2'b01, 10'h013, 32'h0, 32'h0, 1'b1, 1);
        chk("err_no_ram_en", {31'd0, acc_en}, 32'd0);

        // More lanes and illegal forms.
        send(1'b1, 2'b01, 10'h012, 32'h0000BEEF, 32'h0, 1'b0, 2);
        send(1'b0, 2'b01, 10'h010, 32'h0, 32'h00001122, 1'b0, 2);
        send(1'b0, 2'b00, 10'h010, 32'h0, 32'h00000011, 1'b0, 2);
        send(1'b0, 2'b00, 10'h013, 32'h0, 32'h000000EF, 1'b0, 2);
        send(1'b0, 2'b11, 10'h010, 32'h0, 32'h0, 1'b1, 1);
        send(1'b0, 2'b10, 10'h011, 32'h0, 32'h0, 1'b1, 1);
        send(1'b1, 2'b10, 10'h012, 32'hCAFEF00D, 32'h0, 1'b1, 1);
        chk("err_w_no_ram_en", {31'd0, acc_en}, 32'd0);
        drain();
        chk("ram4_word", mem[4], 32'h1122BEEF);

        // Backpressure: two reads fit, the third waits until responses drain.
        send(1'b1, 2'b10, 10'h020, 32'hA0A0A0A0, 32'h0, 1'b0, 1);
        send(1'b1, 2'b10, 10'h024, 32'hB1B1B1B1, 32'h0, 1'b0, 1);
        send(1'b1, 2'b10, 10'h028, 32'hC2C2C2C2, 32'h0, 1'b0, 1);
        drain();
        rsp_ready = 1'b0;
        send(1'b0, 2'b10, 10'h020, 32'h0, 32'hA0A0A0A0, 1'b0, 2);
        send(1'b0, 2'b10, 10'h024, 32'h0, 32'hB1B1B1B1, 1'b0, 0);
        drive(1'b0, 2'b10, 10'h028, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_ready_low", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_acc(32'hC2C2C2C2, 1'b0, 0, 1'b1);
        drain();

        // Reset during the write half of a BYTE read-modify-write.
        send(1'b1, 2'b10, 10'h014, 32'h55667788, 32'h0, 1'b0, 1);
        drain();
        drive(1'b1, 2'b00, 10'h015, 32'h000000FF);
        wait_acc(32'h0, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("mrst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        #2;
        chk("mrst_ready_after", {31'd0, req_ready}, 32'd1);
        idle(3);
        chk("ram5_untouched", mem[5], 32'h55667788);

        // Port still usable after the abandoned write.
        send(1'b0, 2'b00, 10'h015, 32'h0, 32'h00000066, 1'b0, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
